// File: rtl/flappy_pkg.sv
// Shared types and 7-segment constants for the Flappy Bird round logic.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package flappy_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    WON  = 2'd2,
    LOST = 2'd3
  } round_state_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/flappy_round_ctrl_seg7_decode.sv
// Combinational 4-bit value to active-low 7-segment pattern.
// Values above 9 blank the digit.
module seg7_decode
  import flappy_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (value)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/flappy_round_ctrl.sv
// Per-round controller: score, win/lose decision, score digit.
// Optional collision grace period built with FLAPPY_GRACE_EN.
module flappy_round_ctrl
  import flappy_pkg::*;
#(
  parameter int unsigned TARGET      = 8,
  parameter int unsigned GRACE_TICKS = 3
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Tick,
  input  logic       PipePassed,
  input  logic       Collide,
  input  logic       Button,
  input  logic       ResetGame,
  output logic       LED,
  output logic       Lost,
  output logic       Running,
  output logic [6:0] ScoreHex
);

  if (TARGET < 1 || TARGET > 9) begin : g_bad_target
    $error("TARGET out of range 1..9");
  end
  if (GRACE_TICKS < 1 || GRACE_TICKS > 15) begin : g_bad_grace
    $error("GRACE_TICKS out of range 1..15");
  end

  round_state_t state, state_d;
  logic [3:0]   score, score_d;
  logic         button_q;
  logic         press;
  logic         collide_ok;

  assign press = Button & ~button_q;

`ifdef FLAPPY_GRACE_EN
  logic [3:0] grace, grace_d;

  assign collide_ok = Collide & (grace == 4'(GRACE_TICKS));

  always_comb begin
    grace_d = grace;
    unique case (state)
      IDLE, LOST: if (press) grace_d = '0;
      PLAY: begin
        if (Tick && grace != 4'(GRACE_TICKS))
          grace_d = grace + 4'd1;
      end
      default: grace_d = grace;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) grace <= '0;
    else        grace <= grace_d;
  end
`else
  logic unused_tick;

  assign unused_tick = Tick;
  assign collide_ok  = Collide;
`endif

  always_comb begin
    state_d = state;
    score_d = score;
    if (ResetGame) begin
      state_d = IDLE;
      score_d = '0;
    end else begin
      unique case (state)
        IDLE, LOST: begin
          if (press) begin
            state_d = PLAY;
            score_d = '0;
          end
        end
        PLAY: begin
          if (collide_ok) begin
            state_d = LOST;
          end else if (PipePassed) begin
            score_d = score + 4'd1;
            if (score == 4'(TARGET - 1))
              state_d = WON;
          end
        end
        WON: state_d = WON;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      score    <= '0;
      button_q <= 1'b0;
    end else begin
      state    <= state_d;
      score    <= score_d;
      button_q <= Button;
    end
  end

  assign LED     = (state == WON);
  assign Lost    = (state == LOST);
  assign Running = (state == PLAY);

  seg7_decode u_seg (
    .value (score),
    .seg   (ScoreHex)
  );

endmodule

// File: tb/tb_flappy_round_ctrl.sv
// Randomized and directed bench for flappy_round_ctrl.
// Build with FLAPPY_GRACE_EN to exercise the grace period.
module tb_flappy_round_ctrl;

  localparam int TGT = 8;
  localparam int GR  = 3;
`ifdef FLAPPY_GRACE_EN
  localparam bit GRACE = 1'b1;
`else
  localparam bit GRACE = 1'b0;
`endif

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       Tick = 0, PipePassed = 0, Collide = 0;
  logic       Button = 0, ResetGame = 0;
  logic       LED, Lost, Running;
  logic [6:0] ScoreHex;

  int total = 0;
  int bad = 0;

  logic [6:0] seg_tab [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  // reference: round phase as a string plus plain counters
  string m_phase;
  int    m_score;
  int    m_ticks;
  bit    m_prev_btn;

  flappy_round_ctrl #(.TARGET(TGT), .GRACE_TICKS(GR)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Tick       (Tick),
    .PipePassed (PipePassed),
    .Collide    (Collide),
    .Button     (Button),
    .ResetGame  (ResetGame),
    .LED        (LED),
    .Lost       (Lost),
    .Running    (Running),
    .ScoreHex   (ScoreHex)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_phase    = "idle";
    m_score    = 0;
    m_ticks    = 0;
    m_prev_btn = 0;
  endtask

  task automatic model_step(input bit b, input bit p, input bit c,
                            input bit t, input bit rg);
    bit pr;
    bit armed;
    pr = b && !m_prev_btn;
    m_prev_btn = b;
    if (rg) begin
      m_phase = "idle";
      m_score = 0;
    end else if (m_phase == "idle" || m_phase == "lost") begin
      if (pr) begin
        m_phase = "play";
        m_score = 0;
        m_ticks = 0;
      end
    end else if (m_phase == "play") begin
      armed = !GRACE || (m_ticks >= GR);
      if (t) m_ticks++;
      if (c && armed) m_phase = "lost";
      else if (p) begin
        m_score++;
        if (m_score == TGT) m_phase = "won";
      end
    end
  endtask

  task automatic compare(input string tag);
    chk({tag, ".led"}, LED, m_phase == "won");
    chk({tag, ".lost"}, Lost, m_phase == "lost");
    chk({tag, ".run"}, Running, m_phase == "play");
    chk({tag, ".hex"}, ScoreHex, seg_tab[m_score]);
  endtask

  task automatic step(input string tag, input bit b, input bit p,
                      input bit c, input bit t, input bit rg);
    Button = b; PipePassed = p; Collide = c; Tick = t; ResetGame = rg;
    model_step(b, p, c, t, rg);
    @(negedge Clock);
    compare(tag);
  endtask

  initial begin
    model_reset();
    #1;
    chk("rst.led", LED, 0);
    chk("rst.lost", Lost, 0);
    chk("rst.run", Running, 0);
    chk("rst.hex", ScoreHex, 7'b1000000);
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b1;
    compare("rst2");

    step("start", 1, 0, 0, 0, 0);
    chk("start.run", Running, 1);
    chk("start.hex", ScoreHex, 7'b1000000);
    step("rel", 0, 0, 0, 0, 0);
    step("hold", 0, 0, 0, 0, 0);

    for (int i = 1; i <= TGT; i++) begin
      step($sformatf("pipe%0d", i), 0, 1, 0, 0, 0);
      if (i < TGT) chk($sformatf("pipe%0d.hex", i), ScoreHex, seg_tab[i]);
    end
    chk("won.led", LED, 1);
    chk("won.run", Running, 0);
    step("pipe9", 0, 1, 1, 0, 0);
    chk("pipe9.hex", ScoreHex, 7'b0000000);
    step("won.press", 1, 0, 0, 0, 0);
    step("won.rel", 0, 0, 0, 0, 0);
    chk("won.stay", LED, 1);

    step("rg", 1, 0, 0, 0, 1);
    chk("rg.led", LED, 0);
    chk("rg.run", Running, 0);
    chk("rg.hex", ScoreHex, 7'b1000000);
    step("rg.held", 1, 0, 0, 0, 0);
    step("rg.rel", 0, 0, 0, 0, 0);
    step("rg.press", 1, 0, 0, 0, 0);
    chk("rg.press.run", Running, 1);
    step("rg.rel2", 0, 0, 0, 0, 0);

    for (int i = 0; i < GR; i++) step("arm", 0, 0, 0, 1, 0);
    for (int i = 0; i < 7; i++) step("to7", 0, 1, 0, 0, 0);
    step("cp", 0, 1, 1, 0, 0);
    chk("cp.lost", Lost, 1);
    chk("cp.hex", ScoreHex, 7'b1111000);
    step("lost.press", 1, 0, 0, 0, 0);
    chk("lost.press.run", Running, 1);
    chk("lost.press.hex", ScoreHex, 7'b1000000);
    step("lost.rel", 0, 0, 0, 0, 0);

`ifdef FLAPPY_GRACE_EN
    step("g.t1", 0, 0, 1, 1, 0);
    step("g.t2", 0, 0, 1, 1, 0);
    chk("g.t2.run", Running, 1);
    step("g.t3", 0, 0, 1, 1, 0);
    chk("g.t3.run", Running, 1);
    step("g.hit", 0, 0, 1, 0, 0);
    chk("g.hit.lost", Lost, 1);
    step("g.press", 1, 0, 0, 0, 0);
    step("g.rel", 0, 0, 0, 0, 0);
`endif

    for (int i = 0; i < 5; i++) step("to5", 0, 1, 0, 0, 0);
    chk("to5.hex", ScoreHex, 7'b0010010);
    #2;
    Reset = 1'b0;
    #1;
    chk("arst.led", LED, 0);
    chk("arst.lost", Lost, 0);
    chk("arst.run", Running, 0);
    chk("arst.hex", ScoreHex, 7'b1000000);
    model_reset();
    Button = 0; PipePassed = 0; Collide = 0; Tick = 0; ResetGame = 0;
    @(negedge Clock);
    Reset = 1'b1;
    compare("arst2");

    for (int i = 0; i < 4000; i++) begin
      bit b, p, c, t, rg;
      b  = ($urandom_range(0, 99) < 35);
      p  = ($urandom_range(0, 99) < 40);
      c  = ($urandom_range(0, 99) < 4);
      t  = ($urandom_range(0, 99) < 30);
      rg = (b && LED && $urandom_range(0, 1) == 1) ||
           ($urandom_range(0, 199) == 0);
      step("rnd", b, p, c, t, rg);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/flappy_round_ctrl.md
# flappy_round_ctrl

Per-round game controller for Flappy Bird. It counts pipes cleared in the current round, declares a round won or lost, and drives the round-won `LED` into the win-tally FSM. It consumes that FSM's `ResetGame` pulse to start the next round. It sits between the playfield/collision logic and the win-tally block, and also drives one active-low 7-segment digit with the live score.

## Interface
Parameters:
- `TARGET`, 8: pipes needed to win a round; legal range 1..9.
- `GRACE_TICKS`, 3: number of `Tick` strobes for which `Collide` is ignored after entering PLAY. Used only with `FLAPPY_GRACE_EN`; legal range 1..15.

Ports:
- `Clock` in 1: system clock.
- `Reset` in 1: asynchronous, active-low reset.
- `Tick` in 1: one-cycle game-step strobe.
- `PipePassed` in 1: one-cycle pulse when the bird clears a pipe.
- `Collide` in 1: level; the bird is touching a pipe or the ground.
- `Button` in 1: synchronized player button, level.
- `ResetGame` in 1: one-cycle pulse from the win-tally FSM.
- `LED` out 1: round won.
- `Lost` out 1: round lost.
- `Running` out 1: round in progress.
- `ScoreHex` out 7: current score on a 7-segment digit, active-low, segment order {g,f,e,d,c,b,a}.

## Operation
Button handling:
- `press` = `Button & ~Button_q`, where `Button_q` is a registered copy of `Button`.

States: IDLE, PLAY, WON, LOST. Score register is 4 bits.

Priority, highest first:
1. `Reset`.
2. `ResetGame`: in any state, go to IDLE and set score to 0.
3. The per-state rules below.

Per-state rules:
- IDLE: on `press`, go to PLAY, set score to 0, set grace counter to 0.
- PLAY:
  - `Collide` (qualified by grace, see Configuration) goes to LOST; score holds its value.
  - Else `PipePassed` increments score. If score was `TARGET-1`, score becomes `TARGET` and state goes to WON.
  - If `Collide` and `PipePassed` occur in the same cycle, `Collide` wins and there is no increment.
- WON: hold. `PipePassed`, `Collide` and `press` are ignored; exit only via `ResetGame`.
  - The tally FSM's final stage issues no `ResetGame`, so WON persists by design.
- LOST: on `press`, go to PLAY, set score to 0, reset the grace counter.

Outputs are decoded from registers only:
- `LED` = (state == WON).
- `Lost` = (state == LOST).
- `Running` = (state == PLAY).
- `ScoreHex` = 7-segment decode of the score: 0→7'b1000000, 1→7'b1111001, 2→7'b0100100, 3→7'b0110000, 4→7'b0011001, 5→7'b0010010, 6→7'b0000010, 7→7'b1111000, 8→7'b0000000, 9→7'b0010000. Any other value → 7'b1111111 (blank).

## Timing
- Reset values:
  - State IDLE, score 0, `Button_q` 0, grace counter 0.
  - `LED`=0, `Lost`=0, `Running`=0, `ScoreHex`=7'b1000000.
  - Outputs take these values immediately on `Reset` low, with no clock edge needed.
- Latency: an input event in cycle N is reflected on outputs in cycle N+1. This applies to `press`→`Running`, `PipePassed`→`ScoreHex`/`LED`, and `Collide`→`Lost`.
- `ResetGame` arrives in the same cycle as `Button` (the tally FSM decodes it combinationally from `Button & LED`). Next cycle: IDLE with `LED`=0. That `press` does not also start a round; the player presses again.
- A held `Button` produces exactly one `press`.
- Score never wraps: it saturates at `TARGET` by construction.

## Configuration
- `FLAPPY_GRACE_EN` defined:
  - A 4-bit grace counter increments on `Tick` while in PLAY, saturating at `GRACE_TICKS`.
  - `Collide` is honored only once the counter equals `GRACE_TICKS`.
- `FLAPPY_GRACE_EN` undefined:
  - No counter is built.
  - `Collide` is honored from the first PLAY cycle.

## Structure
- `flappy_pkg` holds:
  - the `round_state_t` enum {IDLE, PLAY, WON, LOST};
  - the active-low segment constants for digits 0-9 and blank, also reused by the win-tally block.
- One sub-module, `seg7_decode`: purely combinational, 4-bit value in, 7-bit active-low pattern out.

## Test plan
- Reset low, then high; pulse `Button` → next cycle `Running`=1, `ScoreHex`=7'b1000000.
- In PLAY, 8 `PipePassed` pulses with `TARGET`=8:
  - `ScoreHex` steps 1..7;
  - after the 8th pulse, `LED`=1 and `Running`=0;
  - a 9th pulse leaves the score at 8 (7'b0000000).
- In WON, raise `Button` and `ResetGame` together → next cycle IDLE, `LED`=0, `ScoreHex`=7'b1000000; a second `press` → `Running`=1.
- `Collide` and `PipePassed` in the same cycle at score 7 → `Lost`=1, score stays 7 (7'b1111000); then `press` → PLAY with score 0.
- With `FLAPPY_GRACE_EN` and `GRACE_TICKS`=3:
  - `Collide` held from PLAY entry is ignored across 2 `Tick`s;
  - `Lost`=1 on the cycle after the 3rd `Tick`.
- Mid-PLAY at score 5, drive `Reset` low between clock edges → all outputs reach reset values before the next edge.
